char_pixel_sequencer: RTL and testbench

Sequences the 5x7 character-font ROM for the WS2812B peripheral. It accepts one ASCII code plus foreground and background colours per handshake, and drives the ROM address. It latches the 35-bit glyph and streams it as 35 ordered 24-bit pixel colours to the LED bit-serialiser over a valid/ready interface. Optional serpentine ordering matches zig-zag wired matrices.

---
 rtl/char_pixel_sequencer_if.sv | 26 ++
 rtl/char_pixel_sequencer.sv | 139 +++++++++++++
 tb/tb_char_pixel_sequencer.sv | 396 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/char_pixel_sequencer_if.sv
// Character request and pixel stream links of the glyph pixel sequencer.
interface char_pixel_sequencer_if;
   logic        char_valid;
   logic        char_ready;
   logic [6:0]  char_code;
   logic [23:0] fg_color;
   logic [23:0] bg_color;
   logic        serpentine;
   logic        pix_valid;
   logic        pix_ready;
   logic [23:0] pix_rgb;
   logic        pix_first;
   logic        pix_last;

   // Requester / pixel sink side
   modport master (
      output char_valid, char_code, fg_color, bg_color, serpentine, pix_ready,
      input  char_ready, pix_valid, pix_rgb, pix_first, pix_last
   );

   // Sequencer side
   modport slave (
      input  char_valid, char_code, fg_color, bg_color, serpentine, pix_ready,
      output char_ready, pix_valid, pix_rgb, pix_first, pix_last
   );
endinterface

// File: rtl/char_pixel_sequencer.sv
// Fetches a 5x7 glyph from the font ROM and streams it as GRB pixels,
// row-major, with optional column reversal on odd rows for zig-zag matrices.
//
// state | meaning
// IDLE  | waiting for a character request, char_ready high
// LOAD  | rom_addr holds the code, glyph captured from rom_data
// EMIT  | presenting glyph pixels one per handshake
module char_pixel_sequencer #(
   parameter int COLS       = 5,
   parameter int ROWS       = 7,
   parameter int DATA_WIDTH = 35,
   parameter int ADDR_WIDTH = 7
) (
   input  logic                  clk,
   input  logic                  rst_n,
   char_pixel_sequencer_if.slave bus,
   input  logic                  flush,
   output logic [ADDR_WIDTH-1:0] rom_addr,
   input  logic [DATA_WIDTH-1:0] rom_data,
   output logic                  busy
);

   localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [COL_W-1:0]      COL_LAST = COL_W'(COLS - 1);
   localparam logic [ROW_W-1:0]      ROW_LAST = ROW_W'(ROWS - 1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_RST = ADDR_WIDTH'(32);

   typedef enum logic [1:0] {IDLE, LOAD, EMIT} state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [23:0]           fg_q, fg_d;
   logic [23:0]           bg_q, bg_d;
   logic                  serp_q, serp_d;
   logic [DATA_WIDTH-1:0] glyph_q, glyph_d;
   logic [ROW_W-1:0]      row_q, row_d;
   logic [COL_W-1:0]      col_q, col_d;

   logic [COL_W-1:0]      col_sel;
   logic [IDX_W-1:0]      bit_idx;
   logic                  emit;

   // Next-state: accept, glyph capture, pixel advance; flush overrides all
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      fg_d    = fg_q;
      bg_d    = bg_q;
      serp_d  = serp_q;
      glyph_d = glyph_q;
      row_d   = row_q;
      col_d   = col_q;
      case (state_q)
         IDLE: begin
            if (bus.char_valid) begin
               addr_d  = ADDR_WIDTH'(bus.char_code);
               fg_d    = bus.fg_color;
               bg_d    = bus.bg_color;
               serp_d  = bus.serpentine;
               state_d = LOAD;
            end
         end
         LOAD: begin
            glyph_d = rom_data;
            row_d   = '0;
            col_d   = '0;
            state_d = EMIT;
         end
         EMIT: begin
            if (bus.pix_ready) begin
               if (col_q == COL_LAST) begin
                  col_d = '0;
                  if (row_q == ROW_LAST) begin
                     row_d   = '0;
                     state_d = IDLE;
                  end else begin
                     row_d = row_q + ROW_W'(1);
                  end
               end else begin
                  col_d = col_q + COL_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
      // A flush in IDLE also blocks the pending request, hence placed last.
      if (flush) begin
         state_d = IDLE;
         addr_d  = addr_q;
         fg_d    = fg_q;
         bg_d    = bg_q;
         serp_d  = serp_q;
         row_d   = '0;
         col_d   = '0;
      end
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         addr_q  <= ADDR_RST;
         fg_q    <= '0;
         bg_q    <= '0;
         serp_q  <= 1'b0;
         glyph_q <= '0;
         row_q   <= '0;
         col_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         fg_q    <= fg_d;
         bg_q    <= bg_d;
         serp_q  <= serp_d;
         glyph_q <= glyph_d;
         row_q   <= row_d;
         col_q   <= col_d;
      end
   end

   // Pixel select: all inputs are registers, so outputs hold during stalls.
   always_comb begin
      col_sel = (serp_q && row_q[0]) ? (COL_LAST - col_q) : col_q;
      bit_idx = IDX_W'(DATA_WIDTH - 1)
              - (IDX_W'(row_q) * IDX_W'(COLS) + IDX_W'(col_sel));
   end

   assign emit           = (state_q == EMIT);
   assign busy           = (state_q != IDLE);
   assign rom_addr       = addr_q;
   assign bus.char_ready = (state_q == IDLE);
   assign bus.pix_valid  = emit;
   assign bus.pix_rgb    = emit ? (glyph_q[bit_idx] ? fg_q : bg_q) : 24'h0;
   assign bus.pix_first  = emit && (row_q == '0) && (col_q == '0);
   assign bus.pix_last   = emit && (row_q == ROW_LAST) && (col_q == COL_LAST);

endmodule

// File: tb/tb_char_pixel_sequencer.sv
// Bench for char_pixel_sequencer: transaction-level model of the pixel
// stream, per-cycle compare against it, plus directed literal expectations.
module tb_char_pixel_sequencer;
   localparam int COLS   = 5;
   localparam int ROWS   = 7;
   localparam int NPIX   = COLS * ROWS;
   localparam int P_IDLE = 0;
   localparam int P_LOAD = 1;
   localparam int P_EMIT = 2;
   // Test font entry for 'A'; row 1 is deliberately asymmetric.
   localparam logic [34:0] GLYPH_A = 35'b01110_11000_10001_11111_10001_10001_10001;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        flush;
   logic [6:0]  rom_addr;
   logic [34:0] rom_data;
   logic        busy;

   char_pixel_sequencer_if bus();

   always #5 clk = ~clk;

   function automatic logic [34:0] rom_fn(input logic [6:0] a);
      if (a < 7'd32 || a > 7'd126) return '1;
      if (a == 7'h41) return GLYPH_A;
      return {a, a ^ 7'h55, 7'(a * 3), 7'(a + 7'd9), a ^ 7'h2A};
   endfunction

   assign rom_data = rom_fn(rom_addr);

   char_pixel_sequencer #(.COLS(5), .ROWS(7), .DATA_WIDTH(35), .ADDR_WIDTH(7)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus),
      .flush    (flush),
      .rom_addr (rom_addr),
      .rom_data (rom_data),
      .busy     (busy)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic timeout(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: timed out at %0t", name, $time);
   endtask

   // Expected colour of pixel p of a glyph
   function automatic logic [23:0] pix_exp(input logic [34:0] g, input int p, input logic s,
                                           input logic [23:0] f, input logic [23:0] b);
      int r = p / COLS;
      int c = p % COLS;
      if (s && (r % 2 == 1)) c = COLS - 1 - c;
      return g[NPIX - 1 - (r * COLS + c)] ? f : b;
   endfunction

   typedef struct {
      logic [6:0]  code;
      logic [23:0] fg;
      logic [23:0] bg;
      logic        serp;
   } req_t;

   req_t reqs [64];
   int   req_wr = 0;
   int   req_rd = 0;

   task automatic push(input logic [6:0] c, input logic [23:0] f, input logic [23:0] b, input logic s);
      reqs[req_wr % 64] = '{c, f, b, s};
      req_wr++;
   endtask

   // Requester: presents the oldest unaccepted request, holding it until taken
   initial begin
      bus.char_valid = 1'b0;
      bus.char_code  = '0;
      bus.fg_color   = '0;
      bus.bg_color   = '0;
      bus.serpentine = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (req_rd != req_wr) begin
            bus.char_valid = 1'b1;
            bus.char_code  = reqs[req_rd % 64].code;
            bus.fg_color   = reqs[req_rd % 64].fg;
            bus.bg_color   = reqs[req_rd % 64].bg;
            bus.serpentine = reqs[req_rd % 64].serp;
         end else begin
            bus.char_valid = 1'b0;
         end
      end
   end

   // Sink readiness and flush
   int rdy_mode    = 0;
   bit flush_force = 1'b0;
   bit rand_flush  = 1'b0;
   initial begin
      int pi = 0;
      bus.pix_ready = 1'b0;
      flush = 1'b0;
      forever begin
         @(posedge clk);
         #3;
         case (rdy_mode)
            1:       bus.pix_ready = ((pi % 4) == 0) || ((pi % 4) == 3);
            2:       bus.pix_ready = ($urandom_range(0, 1) == 1);
            default: bus.pix_ready = 1'b1;
         endcase
         pi++;
         flush = flush_force || (rand_flush && ($urandom_range(0, 63) == 0));
      end
   end

   // Reference model: where in the glyph stream the block must be
   int          m_phase = P_IDLE;
   int          m_k     = 0;
   int          m_acc_n = 0;
   int          cyc     = 0;
   logic [6:0]  m_code  = '0;
   logic [23:0] m_pix [NPIX];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_phase <= P_IDLE;
         m_k     <= 0;
      end else begin
         cyc <= cyc + 1;
         if (m_phase == P_IDLE) begin
            if (!flush && bus.char_valid) begin
               for (int p = 0; p < NPIX; p++)
                  m_pix[p] <= pix_exp(rom_fn(bus.char_code), p, bus.serpentine,
                                      bus.fg_color, bus.bg_color);
               m_code  <= bus.char_code;
               m_phase <= P_LOAD;
               req_rd  <= req_rd + 1;
               m_acc_n <= m_acc_n + 1;
            end
         end else if (m_phase == P_LOAD) begin
            m_k     <= 0;
            m_phase <= flush ? P_IDLE : P_EMIT;
         end else begin
            if (bus.pix_ready) begin
               if (m_k == NPIX - 1) m_phase <= P_IDLE;
               else m_k <= m_k + 1;
            end
            if (flush) m_phase <= P_IDLE;
         end
      end
   end

   // Per-cycle compare and capture of delivered pixels
   logic [23:0] got [$];
   logic        prev_stall = 1'b0;
   logic        prev_flush = 1'b0;
   logic [23:0] prev_rgb   = '0;
   logic        prev_first = 1'b0;
   logic        prev_last  = 1'b0;

   always @(negedge clk) begin
      chk("char_ready", bus.char_ready, m_phase == P_IDLE);
      chk("busy", busy, m_phase != P_IDLE);
      chk("pix_valid", bus.pix_valid, m_phase == P_EMIT);
      if (m_phase == P_LOAD) chk("rom_addr", rom_addr, m_code);
      if (m_phase == P_EMIT) begin
         chk("pix_rgb", bus.pix_rgb, m_pix[m_k]);
         chk("pix_first", bus.pix_first, m_k == 0);
         chk("pix_last", bus.pix_last, m_k == NPIX - 1);
      end
      if (rst_n && bus.pix_valid && prev_stall && !prev_flush) begin
         chk("stall_rgb", bus.pix_rgb, prev_rgb);
         chk("stall_first", bus.pix_first, prev_first);
         chk("stall_last", bus.pix_last, prev_last);
      end
      if (bus.pix_valid && bus.pix_ready) got.push_back(bus.pix_rgb);
      prev_stall <= rst_n && bus.pix_valid && !bus.pix_ready;
      prev_flush <= flush;
      prev_rgb   <= bus.pix_rgb;
      prev_first <= bus.pix_first;
      prev_last  <= bus.pix_last;
   end

   task automatic wait_idle(input int max, input string name);
      int n = 0;
      while (!(m_phase == P_IDLE && req_rd == req_wr) && n < max) begin
         @(posedge clk);
         #2;
         n++;
      end
      if (n >= max) timeout(name);
   endtask

   task automatic wait_pixel(input int k, input string name);
      int n = 0;
      while (!(m_phase == P_EMIT && m_k == k) && n < 500) begin
         @(posedge clk);
         #2;
         n++;
      end
      if (n >= 500) timeout(name);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   localparam logic [23:0] GRN = 24'h00FF00;

   initial begin
      int base;
      int a0;
      int t0;
      int t1;
      int fv;
      int rb;
      int nbad;
      logic [23:0] sa [NPIX];

      #1 rst_n = 1'b0;
      #2;
      chk("rst_char_ready", bus.char_ready, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_pix_valid", bus.pix_valid, 1'b0);
      chk("rst_pix_first", bus.pix_first, 1'b0);
      chk("rst_pix_last", bus.pix_last, 1'b0);
      chk("rst_pix_rgb", bus.pix_rgb, 24'h0);
      chk("rst_rom_addr", rom_addr, 7'h20);
      #19 rst_n = 1'b1;
      @(posedge clk);
      #2;

      // 'A', plain order, sink always ready: latency and literal pixels
      base = got.size();
      a0 = m_acc_n;
      push(7'h41, GRN, 24'h0, 1'b0);
      t0 = -1; fv = -1; rb = -1;
      for (int i = 0; i < 200 && rb < 0; i++) begin
         @(posedge clk);
         #2;
         if (t0 < 0 && m_acc_n != a0) t0 = cyc;
         else if (t0 >= 0) begin
            if (fv < 0 && bus.pix_valid) fv = cyc + 1;
            if (bus.char_ready) rb = cyc + 1;
         end
      end
      if (rb < 0) timeout("a_ready_return");
      chk("first_pixel_cycle", 64'(fv - t0), 64'd2);
      chk("ready_return_cycle", 64'(rb - t0), 64'd37);
      chk("a_count", 64'(got.size() - base), 64'd35);
      for (int p = 0; p < NPIX; p++) sa[p] = got[base + p];
      chk("a_pix0", sa[0], 24'h0);
      chk("a_pix1", sa[1], GRN);
      chk("a_pix5", sa[5], GRN);
      chk("a_pix6", sa[6], GRN);
      chk("a_pix7", sa[7], 24'h0);
      chk("a_pix9", sa[9], 24'h0);
      chk("a_pix34", sa[34], GRN);

      // Same request with a stalling sink
      rdy_mode = 1;
      base = got.size();
      push(7'h41, GRN, 24'h0, 1'b0);
      wait_idle(300, "stall_done");
      chk("stall_count", 64'(got.size() - base), 64'd35);
      for (int p = 0; p < NPIX; p++) chk("stall_seq", got[base + p], sa[p]);
      rdy_mode = 0;

      // Serpentine: row 1 reversed, rows 0 and 2 unchanged
      base = got.size();
      push(7'h41, GRN, 24'h0, 1'b1);
      wait_idle(200, "serp_done");
      chk("serp_pix5", got[base + 5], 24'h0);
      chk("serp_pix6", got[base + 6], 24'h0);
      chk("serp_pix7", got[base + 7], 24'h0);
      chk("serp_pix8", got[base + 8], GRN);
      chk("serp_pix9", got[base + 9], GRN);
      for (int p = 0; p < 5; p++) begin
         chk("serp_row0", got[base + p], sa[p]);
         chk("serp_row2", got[base + 10 + p], sa[10 + p]);
      end

      // Out-of-range code: all foreground
      base = got.size();
      push(7'h7F, 24'h123456, 24'h654321, 1'b0);
      wait_idle(200, "oor_done");
      chk("oor_count", 64'(got.size() - base), 64'd35);
      nbad = 0;
      for (int p = 0; p < NPIX; p++) if (got[base + p] != 24'h123456) nbad++;
      chk("oor_all_fg", 64'(nbad), 64'd0);

      // Flush on the 10th handshake, then a fresh character
      base = got.size();
      push(7'h52, 24'hABCDEF, 24'h010203, 1'b0);
      wait_pixel(9, "flush10_wait");
      flush_force = 1'b1;
      @(posedge clk);
      #2;
      flush_force = 1'b0;
      chk("flush_pix_valid", bus.pix_valid, 1'b0);
      chk("flush_busy", busy, 1'b0);
      repeat (3) @(posedge clk);
      #2;
      chk("flush_count", 64'(got.size() - base), 64'd10);
      base = got.size();
      push(7'h52, 24'hABCDEF, 24'h010203, 1'b1);
      wait_idle(200, "after_flush_done");
      chk("after_flush_count", 64'(got.size() - base), 64'd35);

      // Flush on the last handshake: pixel still delivered
      base = got.size();
      push(7'h30, 24'h111111, 24'h222222, 1'b0);
      wait_pixel(34, "flush_last_wait");
      flush_force = 1'b1;
      @(posedge clk);
      #2;
      flush_force = 1'b0;
      chk("flush_last_busy", busy, 1'b0);
      chk("flush_last_count", 64'(got.size() - base), 64'd35);

      // Flush in IDLE beats a pending request
      wait_idle(50, "idle_flush_pre");
      push(7'h33, 24'h0000FF, 24'hFF0000, 1'b0);
      @(posedge clk);
      #2;
      flush_force = 1'b1;
      @(posedge clk);
      #2;
      flush_force = 1'b0;
      chk("idle_flush_busy", busy, 1'b0);
      chk("idle_flush_ready", bus.char_ready, 1'b1);
      @(posedge clk);
      #2;
      chk("idle_flush_accept_after", busy, 1'b1);
      wait_idle(200, "idle_flush_done");

      // Request held while busy: accepted only once IDLE returns
      a0 = m_acc_n;
      push(7'h41, GRN, 24'h0, 1'b0);
      push(7'h7F, 24'h00FFFF, 24'h0, 1'b0);
      t0 = -1; t1 = -1;
      for (int i = 0; i < 200 && t1 < 0; i++) begin
         @(posedge clk);
         #2;
         if (t0 < 0 && m_acc_n == a0 + 1) t0 = cyc;
         if (t1 < 0 && m_acc_n == a0 + 2) t1 = cyc;
      end
      if (t1 < 0) timeout("b2b_second_accept");
      chk("accept_to_accept", 64'(t1 - t0), 64'd37);
      wait_idle(200, "b2b_done");

      // Asynchronous reset in the middle of EMIT
      push(7'h41, GRN, 24'h0, 1'b0);
      wait_pixel(5, "rst_mid_wait");
      #1 rst_n = 1'b0;
      #1;
      chk("arst_pix_valid", bus.pix_valid, 1'b0);
      chk("arst_char_ready", bus.char_ready, 1'b1);
      chk("arst_busy", busy, 1'b0);
      chk("arst_pix_rgb", bus.pix_rgb, 24'h0);
      chk("arst_pix_first", bus.pix_first, 1'b0);
      chk("arst_pix_last", bus.pix_last, 1'b0);
      chk("arst_rom_addr", rom_addr, 7'h20);
      @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #2;

      // Randomised traffic: codes, colours, ordering, sink stalls, flushes
      rdy_mode = 2;
      rand_flush = 1'b1;
      for (int i = 0; i < 25; i++)
         push(7'($urandom_range(0, 127)), 24'($urandom), 24'($urandom),
              1'($urandom_range(0, 1)));
      wait_idle(25 * 150, "random_done");
      rand_flush = 1'b0;
      rdy_mode = 0;
      repeat (3) @(posedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
